win3x3_gen: RTL

Streaming 3x3 neighbourhood generator that feeds the mean filter. It accepts a raster-order 8-bit pixel stream and buffers two image lines internally. For every interior pixel position, it presents the full 3x3 window P1..P9 (P5 = centre) together with a valid strobe and the centre coordinates. It sits between the pixel source and the combinational filter datapath, which consumes P1–P4 and P6–P9 directly.

---
 rtl/win3x3_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/win3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window
// present every interior window of a raster-order 8-bit pixel stream.
module win3x3_gen #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [7:0]    P1,
    output logic [7:0]    P2,
    output logic [7:0]    P3,
    output logic [7:0]    P4,
    output logic [7:0]    P5,
    output logic [7:0]    P6,
    output logic [7:0]    P7,
    output logic [7:0]    P8,
    output logic [7:0]    P9,
    output logic          win_valid,
    output logic [RW-1:0] cen_row,
    output logic [CW-1:0] cen_col,
    output logic          frame_done
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] pos_col_s;
    logic [RW-1:0] pos_row_s;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;
    logic          win_fire_s;
    logic          last_pix_s;

    logic [7:0]    lb_a_r [IMG_W];
    logic [7:0]    lb_b_r [IMG_W];
    logic [7:0]    lb_a_rd_s;
    logic [7:0]    lb_b_rd_s;

    logic [7:0]    win_r [1:9];
    logic          win_valid_r;
    logic          frame_done_r;
    logic [RW-1:0] cen_row_r;
    logic [CW-1:0] cen_col_r;

    // Position of the pixel being accepted (sof forces (0,0)) and the counters' next value
    always_comb begin
        pos_col_s  = col_r;
        pos_row_s  = row_r;
        col_nxt_s  = col_r;
        row_nxt_s  = row_r;
        win_fire_s = 1'b0;
        last_pix_s = 1'b0;
        if (pix_valid && sof) begin
            pos_col_s = {CW{1'b0}};
            pos_row_s = {RW{1'b0}};
        end else begin
            pos_col_s = col_r;
            pos_row_s = row_r;
        end
        if (pix_valid) begin
            win_fire_s = (pos_row_s >= ROW_TWO) && (pos_col_s >= COL_TWO);
            last_pix_s = (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);
            if (pos_col_s == COL_LAST) begin
                col_nxt_s = {CW{1'b0}};
                if (pos_row_s == ROW_LAST) begin
                    row_nxt_s = {RW{1'b0}};
                end else begin
                    row_nxt_s = pos_row_s + RW'(1);
                end
            end else begin
                col_nxt_s = pos_col_s + CW'(1);
                row_nxt_s = pos_row_s;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // Position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // Reads see pre-write contents because the writes below are non-blocking
    assign lb_a_rd_s = lb_a_r[pos_col_s];
    assign lb_b_rd_s = lb_b_r[pos_col_s];

    // Line buffers: LB_A (line r-1) ages into LB_B (line r-2); contents are never reset
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb_b_r[pos_col_s] <= lb_a_rd_s;
            lb_a_r[pos_col_s] <= pix_in;
        end
    end

    // Window shift register, strobes and centre coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= 9; i++) begin
                win_r[i] <= 8'h00;
            end
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            cen_row_r    <= {RW{1'b0}};
            cen_col_r    <= {CW{1'b0}};
        end else if (pix_valid) begin
            win_r[1]     <= win_r[2];
            win_r[2]     <= win_r[3];
            win_r[3]     <= lb_b_rd_s;
            win_r[4]     <= win_r[5];
            win_r[5]     <= win_r[6];
            win_r[6]     <= lb_a_rd_s;
            win_r[7]     <= win_r[8];
            win_r[8]     <= win_r[9];
            win_r[9]     <= pix_in;
            win_valid_r  <= win_fire_s;
            frame_done_r <= last_pix_s;
            if (win_fire_s) begin
                cen_row_r <= pos_row_s - RW'(1);
                cen_col_r <= pos_col_s - CW'(1);
            end
        end else begin
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end
    end

    assign P1         = win_r[1];
    assign P2         = win_r[2];
    assign P3         = win_r[3];
    assign P4         = win_r[4];
    assign P5         = win_r[5];
    assign P6         = win_r[6];
    assign P7         = win_r[7];
    assign P8         = win_r[8];
    assign P9         = win_r[9];
    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;
    assign cen_row    = cen_row_r;
    assign cen_col    = cen_col_r;

endmodule
